// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command driver: opcode encodings,
// cmd_flags bit positions and the command-validity rule.
package alsu_pkg;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_XOR    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_SHIFT  = 3'b100;
  localparam logic [2:0] OP_ROTATE = 3'b101;

  localparam int OP_W  = 3;
  localparam int FLG_W = 7;

  // cmd_flags = {cin, si, sh_left, red_op_a, red_op_b, pass_a, pass_b}
  localparam int FLG_CIN     = 6;
  localparam int FLG_SI      = 5;
  localparam int FLG_SH_LEFT = 4;
  localparam int FLG_RED_A   = 3;
  localparam int FLG_RED_B   = 2;
  localparam int FLG_PASS_A  = 1;
  localparam int FLG_PASS_B  = 0;

  // Opcode and flag bits carried per FIFO entry (operands excluded).
  localparam int CMD_FIXED_W = OP_W + FLG_W;

  // A command is invalid when the opcode is unassigned, or when a reduction
  // is requested on anything other than a bitwise opcode.
  function automatic logic cmd_invalid(input logic [2:0] op,
                                       input logic       red_a,
                                       input logic       red_b);
    logic known;
    logic bitwise;
    known   = (op == OP_AND) || (op == OP_XOR) || (op == OP_ADD) ||
              (op == OP_MUL) || (op == OP_SHIFT) || (op == OP_ROTATE);
    bitwise = (op == OP_AND) || (op == OP_XOR);
    return !known || ((red_a | red_b) && !bitwise);
  endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Command FIFO for the ALSU driver. Head entry is visible combinationally;
// a push into a full FIFO is refused even if a pop happens in the same cycle.
module alsu_cmd_fifo
  import alsu_pkg::*;
#(
  parameter  int BITS  = 3,
  parameter  int DEPTH = 4,
  localparam int W     = CMD_FIXED_W + 2*BITS,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/alsu_cmd_driver.sv
// ALSU command driver: buffers host commands, issues at most one per cycle
// onto the ALSU inputs, and returns each ALSU result three edges after issue
// tagged with a locally computed invalid flag.
// Optional counters: define ALSU_CMD_DRIVER_STATS_EN.
module alsu_cmd_driver
  import alsu_pkg::*;
#(
  parameter  int BITS  = 3,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [BITS-1:0]   cmd_a,
  input  logic [BITS-1:0]   cmd_b,
  input  logic [6:0]        cmd_flags,
  input  logic              issue_en,
  output logic              alsu_rstn,
  output logic [2:0]        alsu_opcode,
  output logic [BITS-1:0]   alsu_a,
  output logic [BITS-1:0]   alsu_b,
  output logic              alsu_cin,
  output logic              alsu_si,
  output logic              alsu_sh_left,
  output logic              alsu_red_op_a,
  output logic              alsu_red_op_b,
  output logic              alsu_pass_a,
  output logic              alsu_pass_b,
  input  logic [2*BITS-1:0] alsu_out,
  output logic              res_valid,
  output logic [2*BITS-1:0] res_data,
  output logic              res_invalid,
  output logic [LW-1:0]     fifo_level
`ifdef ALSU_CMD_DRIVER_STATS_EN
  ,
  output logic [15:0]       issued_cnt,
  output logic [15:0]       result_cnt,
  output logic [15:0]       invalid_cnt
`endif
);

  localparam int CW = CMD_FIXED_W + 2*BITS;

  logic [CW-1:0]     w_push_data;
  logic [CW-1:0]     w_head;
  logic [2:0]        w_head_op;
  logic [BITS-1:0]   w_head_a;
  logic [BITS-1:0]   w_head_b;
  logic [6:0]        w_head_flags;
  logic              w_head_inv;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  logic              r_rstn;
  logic [2:0]        r_op;
  logic [BITS-1:0]   r_a;
  logic [BITS-1:0]   r_b;
  logic [6:0]        r_flags;
  logic [2:0]        r_tag_v;
  logic [2:0]        r_tag_inv;
  logic              r_res_valid;
  logic [2*BITS-1:0] r_res_data;
  logic              r_res_inv;

  assign w_push_data = {cmd_opcode, cmd_a, cmd_b, cmd_flags};
  assign {w_head_op, w_head_a, w_head_b, w_head_flags} = w_head;
  assign w_head_inv  = cmd_invalid(w_head_op, w_head_flags[FLG_RED_A],
                                   w_head_flags[FLG_RED_B]);

  assign cmd_ready = ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = issue_en & ~w_empty & r_rstn;

  alsu_cmd_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ALSU reset releases on the first edge after rst deasserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstn <= 1'b0;
    else     r_rstn <= 1'b1;
  end

  // Drive the popped command, or an AND of zeros when idle so the ALSU output settles to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= OP_AND;
      r_a     <= '0;
      r_b     <= '0;
      r_flags <= '0;
    end else if (w_pop) begin
      r_op    <= w_head_op;
      r_a     <= w_head_a;
      r_b     <= w_head_b;
      r_flags <= w_head_flags;
    end else begin
      r_op    <= OP_AND;
      r_a     <= '0;
      r_b     <= '0;
      r_flags <= '0;
    end
  end

  // Tag pipeline tracks the two ALSU register stages plus the driver's own issue stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v   <= '0;
      r_tag_inv <= '0;
    end else begin
      r_tag_v   <= {r_tag_v[1:0], w_pop};
      r_tag_inv <= {r_tag_inv[1:0], w_pop & w_head_inv};
    end
  end

  // Capture the ALSU output when the matching tag reaches the end of the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_inv   <= 1'b0;
    end else begin
      r_res_valid <= r_tag_v[2];
      if (r_tag_v[2]) begin
        r_res_data <= alsu_out;
        r_res_inv  <= r_tag_inv[2];
      end
    end
  end

  assign alsu_rstn     = r_rstn;
  assign alsu_opcode   = r_op;
  assign alsu_a        = r_a;
  assign alsu_b        = r_b;
  assign alsu_cin      = r_flags[FLG_CIN];
  assign alsu_si       = r_flags[FLG_SI];
  assign alsu_sh_left  = r_flags[FLG_SH_LEFT];
  assign alsu_red_op_a = r_flags[FLG_RED_A];
  assign alsu_red_op_b = r_flags[FLG_RED_B];
  assign alsu_pass_a   = r_flags[FLG_PASS_A];
  assign alsu_pass_b   = r_flags[FLG_PASS_B];
  assign res_valid     = r_res_valid;
  assign res_data      = r_res_data;
  assign res_invalid   = r_res_inv;

`ifdef ALSU_CMD_DRIVER_STATS_EN
  logic [15:0] r_issued_cnt;
  logic [15:0] r_result_cnt;
  logic [15:0] r_invalid_cnt;

  // Free-running wrap-around activity counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued_cnt  <= '0;
      r_result_cnt  <= '0;
      r_invalid_cnt <= '0;
    end else begin
      if (w_pop)                    r_issued_cnt  <= r_issued_cnt + 16'd1;
      if (r_res_valid)              r_result_cnt  <= r_result_cnt + 16'd1;
      if (r_res_valid && r_res_inv) r_invalid_cnt <= r_invalid_cnt + 16'd1;
    end
  end

  assign issued_cnt  = r_issued_cnt;
  assign result_cnt  = r_result_cnt;
  assign invalid_cnt = r_invalid_cnt;
`endif

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Bench for alsu_cmd_driver: a behavioural ALSU stands in for the real one,
// a queue-based model predicts every output each cycle, and directed
// sequences pin literal results.
module tb_alsu_cmd_driver;
  localparam int BITS  = 3;
  localparam int DEPTH = 4;
  localparam int OW    = 2*BITS;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0]      op;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [6:0]      f;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, issue_en = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_opcode = '0;
  logic [BITS-1:0] cmd_a = '0, cmd_b = '0;
  logic [6:0] cmd_flags = '0;
  logic alsu_rstn;
  logic [2:0] alsu_opcode;
  logic [BITS-1:0] alsu_a, alsu_b;
  logic alsu_cin, alsu_si, alsu_sh_left, alsu_red_op_a, alsu_red_op_b, alsu_pass_a, alsu_pass_b;
  logic [OW-1:0] alsu_out;
  logic res_valid, res_invalid;
  logic [OW-1:0] res_data;
  logic [LW-1:0] fifo_level;
`ifdef ALSU_CMD_DRIVER_STATS_EN
  logic [15:0] issued_cnt, result_cnt, invalid_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alsu_cmd_driver #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flags(cmd_flags), .issue_en(issue_en),
    .alsu_rstn(alsu_rstn), .alsu_opcode(alsu_opcode), .alsu_a(alsu_a), .alsu_b(alsu_b),
    .alsu_cin(alsu_cin), .alsu_si(alsu_si), .alsu_sh_left(alsu_sh_left),
    .alsu_red_op_a(alsu_red_op_a), .alsu_red_op_b(alsu_red_op_b),
    .alsu_pass_a(alsu_pass_a), .alsu_pass_b(alsu_pass_b),
    .alsu_out(alsu_out), .res_valid(res_valid), .res_data(res_data),
    .res_invalid(res_invalid), .fifo_level(fifo_level)
`ifdef ALSU_CMD_DRIVER_STATS_EN
    , .issued_cnt(issued_cnt), .result_cnt(result_cnt), .invalid_cnt(invalid_cnt)
`endif
  );

  // Validity rule written directly from the opcode bits.
  function automatic bit inv_rule(input cmd_t c);
    return (c.op[2] & c.op[1]) | ((c.f[3] | c.f[2]) & (c.op[2] | c.op[1]));
  endfunction

  // ALSU arithmetic; prev is the ALSU output of the previous cycle.
  function automatic logic [OW-1:0] alsu_f(input cmd_t c, input logic [OW-1:0] prev);
    logic [OW-1:0] r;
    r = '0;
    if (!inv_rule(c)) begin
      case (c.op)
        3'd0: r = c.f[3] ? OW'(&c.a) : c.f[2] ? OW'(&c.b) : OW'(c.a & c.b);
        3'd1: r = c.f[3] ? OW'(^c.a) : c.f[2] ? OW'(^c.b) : OW'(c.a ^ c.b);
        3'd2: r = OW'(c.a) + OW'(c.b) + OW'(c.f[6]);
        3'd3: r = OW'(c.a) * OW'(c.b);
        3'd4: r = c.f[4] ? {prev[OW-2:0], c.f[5]} : {c.f[5], prev[OW-1:1]};
        3'd5: r = c.f[4] ? {prev[OW-2:0], prev[OW-1]} : {prev[0], prev[OW-1:1]};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Behavioural ALSU: registers inputs, then registers the result.
  cmd_t s_in;
  always @(posedge clk or negedge alsu_rstn) begin
    if (!alsu_rstn) begin
      s_in     <= '0;
      alsu_out <= '0;
    end else begin
      s_in <= '{alsu_opcode, alsu_a, alsu_b,
                {alsu_cin, alsu_si, alsu_sh_left, alsu_red_op_a, alsu_red_op_b, alsu_pass_a, alsu_pass_b}};
      alsu_out <= alsu_f(s_in, alsu_out);
    end
  end

  // Reference model: FIFO as a queue, results delayed by a 3-slot array.
  cmd_t fq[$];
  bit m_rstn;
  cmd_t m_drv;
  bit pv[3], pi[3];
  logic [OW-1:0] pd[3];
  bit m_rv, m_ri;
  logic [OW-1:0] m_rd;
  bit m_last_iss;
  logic [OW-1:0] m_last_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      m_rstn = 0; m_drv = '0; m_rv = 0; m_rd = '0; m_ri = 0;
      m_last_iss = 0; m_last_res = '0;
      for (int i = 0; i < 3; i++) begin pv[i] = 0; pi[i] = 0; pd[i] = '0; end
    end else begin
      bit do_pop, do_push;
      cmd_t c;
      logic [OW-1:0] r;
      do_pop  = issue_en && fq.size() > 0 && m_rstn;
      do_push = cmd_valid && fq.size() < DEPTH;
      m_rv = pv[2];
      if (pv[2]) begin m_rd = pd[2]; m_ri = pi[2]; end
      pv[2] = pv[1]; pd[2] = pd[1]; pi[2] = pi[1];
      pv[1] = pv[0]; pd[1] = pd[0]; pi[1] = pi[0];
      if (do_pop) begin
        c = fq.pop_front();
        r = alsu_f(c, m_last_iss ? m_last_res : '0);
        pv[0] = 1; pd[0] = r; pi[0] = inv_rule(c);
        m_drv = c; m_last_iss = 1; m_last_res = r;
      end else begin
        pv[0] = 0; pd[0] = '0; pi[0] = 0;
        m_drv = '0; m_last_iss = 0;
      end
      if (do_push) fq.push_back('{cmd_opcode, cmd_a, cmd_b, cmd_flags});
      m_rstn = 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus collection of observed results.
  logic [OW-1:0] obs_d[$];
  bit obs_i[$];
  always begin
    @(posedge clk);
    #1;
    check("cmd_ready", cmd_ready, fq.size() < DEPTH);
    check("fifo_level", fifo_level, fq.size());
    check("alsu_rstn", alsu_rstn, m_rstn);
    check("alsu_cmd", {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_si, alsu_sh_left,
                       alsu_red_op_a, alsu_red_op_b, alsu_pass_a, alsu_pass_b}, m_drv);
    check("res_valid", res_valid, m_rv);
    if (m_rv) begin
      check("res_data", res_data, m_rd);
      check("res_invalid", res_invalid, m_ri);
    end
    if (res_valid === 1'b1) begin
      obs_d.push_back(res_data);
      obs_i.push_back(res_invalid);
    end
  end

  logic [OW-1:0] lit_d[$];
  bit lit_i[$];

  task automatic push(input logic [2:0] op, input int a, input int b, input logic [6:0] f);
    cmd_valid = 1; cmd_opcode = op; cmd_a = BITS'(a); cmd_b = BITS'(b); cmd_flags = f;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic expect_res(input int d, input bit inv);
    lit_d.push_back(OW'(d));
    lit_i.push_back(inv);
  endtask

  task automatic check_lit(input string nm);
    int n;
    n = lit_d.size();
    for (int i = 0; i < 40 && obs_d.size() < n; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    check({nm, "_count"}, obs_d.size(), n);
    for (int i = 0; i < n && i < obs_d.size(); i++) begin
      check({nm, "_data"}, obs_d[i], lit_d[i]);
      check({nm, "_inv"}, obs_i[i], lit_i[i]);
    end
    obs_d.delete(); obs_i.delete(); lit_d.delete(); lit_i.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_alsu_rstn", alsu_rstn, 0);
    check("rst_level", fifo_level, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_opcode", alsu_opcode, 0);
    rst = 0;
    @(negedge clk);
    check("rstn_release", alsu_rstn, 1);
    obs_d.delete(); obs_i.delete();
    issue_en = 1;

    // AND 5 & 3
    push(3'd0, 5, 3, 7'b0);
    expect_res(1, 0);
    check_lit("and");

    // ADD 7+7+1 then MUL 7*7 back to back
    push(3'd2, 7, 7, 7'b1000000);
    push(3'd3, 7, 7, 7'b0);
    expect_res(15, 0); expect_res(49, 0);
    check_lit("add_mul");

    // Fill with issue held: fifth push refused
    issue_en = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1; cmd_opcode = 3'd2; cmd_a = BITS'(i + 1); cmd_b = '0; cmd_flags = '0;
      @(negedge clk);
    end
    cmd_valid = 0;
    check("full_ready", cmd_ready, 0);
    check("full_level", fifo_level, 4);
    issue_en = 1;
    @(negedge clk);
    check("ready_after_pop", cmd_ready, 1);
    for (int i = 1; i <= 4; i++) expect_res(i, 0);
    check_lit("fill_drain");

    // Two consecutive unassigned opcodes
    push(3'd6, 3, 2, 7'b0);
    push(3'd6, 1, 1, 7'b0);
    expect_res(0, 1); expect_res(0, 1);
    check_lit("invalid");

    // ADD 0+1 then SHIFT left with si=1
    push(3'd2, 0, 1, 7'b0);
    push(3'd4, 0, 0, 7'b0110000);
    expect_res(1, 0); expect_res(3, 0);
    check_lit("shift");

    // Reset with commands in flight
    push(3'd2, 1, 1, 7'b0);
    push(3'd2, 2, 2, 7'b0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("rstn_held", alsu_rstn, 0);
    @(negedge clk);
    check("rstn_after", alsu_rstn, 1);
    check_lit("flush");
    push(3'd0, 6, 3, 7'b0);
    expect_res(2, 0);
    check_lit("post_rst");

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [6:0] f;
      rst = ($urandom_range(0, 499) == 0);
      cmd_valid = ($urandom_range(0, 9) < 7);
      issue_en = ($urandom_range(0, 9) < 7);
      cmd_opcode = 3'($urandom_range(0, 7));
      cmd_a = BITS'($urandom);
      cmd_b = BITS'($urandom);
      f = 7'($urandom);
      if ($urandom_range(0, 3) != 0) f[3:2] = 2'b00;
      cmd_flags = f;
      @(negedge clk);
    end
    rst = 0; cmd_valid = 0; issue_en = 1;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
